// File: rtl/vend_pkg.sv
// vend_pkg: FSM states, coin codes and greedy change helpers shared by vend_controller.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CREDIT = 3'd1,
        VEND   = 3'd2,
        CHANGE = 3'd3
    } state_t;

    localparam logic [1:0] COIN_500  = 2'b00;
    localparam logic [1:0] COIN_1000 = 2'b01;
    localparam logic [1:0] COIN_2000 = 2'b10;
    localparam logic [1:0] COIN_5000 = 2'b11;
    localparam int unsigned MIN_COIN = 500;

    function automatic logic [12:0] coin_value(input logic [1:0] code);
        return code == COIN_5000 ? 13'd5000 :
               code == COIN_2000 ? 13'd2000 :
               code == COIN_1000 ? 13'd1000 : 13'd500;
    endfunction

    // Largest denomination not exceeding amount; callers stop below MIN_COIN.
    function automatic logic [1:0] change_coin(input logic [31:0] amount);
        return amount >= 32'd5000 ? COIN_5000 :
               amount >= 32'd2000 ? COIN_2000 :
               amount >= 32'd1000 ? COIN_1000 : COIN_500;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// vend_stock_bank: per-slot stock counters with restock/dispense merge and registered flags.
module vend_stock_bank #(
    parameter int NUM_PRODUCTS = 8,
    parameter int STOCK_W      = 8,
    parameter int INIT_STOCK   = 10,
    parameter int LOW_THRESH   = 5,
    parameter int ID_W         = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    restock_valid,
    input  logic [ID_W-1:0]         restock_id,
    input  logic [STOCK_W-1:0]      restock_qty,
    input  logic                    dec_valid,
    input  logic [ID_W-1:0]         dec_id,
    input  logic [ID_W-1:0]         rd_id,
    output logic [STOCK_W-1:0]      rd_stock,
    output logic [NUM_PRODUCTS-1:0] low_stock,
    output logic [NUM_PRODUCTS-1:0] sold_out
);

    localparam int SLOTS = 1 << ID_W;
    localparam logic [STOCK_W:0]   MAX  = {1'b0, {STOCK_W{1'b1}}};
    localparam logic [STOCK_W-1:0] INIT = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] LOW  = STOCK_W'(LOW_THRESH);

    logic [STOCK_W-1:0]      stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0]      stock_d [NUM_PRODUCTS];
    logic [STOCK_W-1:0]      rd_tab  [SLOTS];
    logic [NUM_PRODUCTS-1:0] low_q, low_d, sold_q, sold_d;
    logic [STOCK_W:0]        sum;

    // Restock and dispense on one slot net out before saturation is applied.
    always_comb begin
        sum    = '0;
        low_d  = '0;
        sold_d = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            sum = {1'b0, stock_q[i]}
                + ((restock_valid && restock_id == ID_W'(i)) ? {1'b0, restock_qty} : '0)
                - (STOCK_W+1)'(dec_valid && dec_id == ID_W'(i));
            stock_d[i] = sum > MAX ? MAX[STOCK_W-1:0] : sum[STOCK_W-1:0];
            low_d[i]   = stock_d[i] <= LOW;
            sold_d[i]  = stock_d[i] == '0;
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) rd_tab[i] = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) rd_tab[i] = stock_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= INIT;
            low_q  <= {NUM_PRODUCTS{INIT <= LOW}};
            sold_q <= {NUM_PRODUCTS{INIT == '0}};
        end else begin
            stock_q <= stock_d;
            low_q   <= low_d;
            sold_q  <= sold_d;
        end
    end

    assign rd_stock  = rd_tab[rd_id];
    assign low_stock = low_q;
    assign sold_out  = sold_q;

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin credit, product selection, dispense handshake and greedy change return.
// Define VEND_BONUS_DISCOUNT_EN to charge 75% on every BONUS_N-th sale.
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_PRODUCTS = 8,
    parameter int CREDIT_W     = 16,
    parameter int STOCK_W      = 8,
    parameter int INIT_STOCK   = 10,
    parameter int LOW_THRESH   = 5,
    parameter int BONUS_N      = 10
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               coin_valid,
    input  logic [1:0]                         coin,
    output logic                               coin_accept,
    output logic                               coin_reject,
    input  logic                               sel_valid,
    input  logic [$clog2(NUM_PRODUCTS)-1:0]    sel_id,
    input  logic                               cancel,
    input  logic [NUM_PRODUCTS*CREDIT_W-1:0]   price_table,
    input  logic                               restock_valid,
    input  logic [$clog2(NUM_PRODUCTS)-1:0]    restock_id,
    input  logic [STOCK_W-1:0]                 restock_qty,
    output logic                               disp_valid,
    output logic [$clog2(NUM_PRODUCTS)-1:0]    disp_id,
    input  logic                               disp_ready,
    output logic                               chg_valid,
    output logic [1:0]                         chg_coin,
    input  logic                               chg_ready,
    output logic [CREDIT_W-1:0]                credit,
    output logic [STOCK_W-1:0]                 stock_out,
    output logic [NUM_PRODUCTS-1:0]            low_stock,
    output logic [NUM_PRODUCTS-1:0]            sold_out,
    output logic                               err_funds,
    output logic                               err_empty,
    output logic [2:0]                         state
);

    localparam int ID_W   = $clog2(NUM_PRODUCTS);
    localparam int SLOTS  = 1 << ID_W;
    localparam int SALE_W = $clog2(BONUS_N) + 1;
    // Padding to a power of two lets out-of-range ids read as empty slots.
    localparam logic [SLOTS-1:0] SLOT_VALID = SLOTS'({NUM_PRODUCTS{1'b1}});

    state_t                  state_q, state_d;
    logic [CREDIT_W-1:0]     credit_q, credit_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [SALE_W-1:0]       sale_q, sale_d;
    logic                    coin_accept_q, coin_accept_d, coin_reject_q, coin_reject_d;
    logic                    err_funds_q, err_funds_d, err_empty_q, err_empty_d;
    logic                    dec_valid, coin_ok;
    logic [CREDIT_W:0]       coin_sum;
    logic [CREDIT_W-1:0]     price, charge;
    logic [SLOTS*CREDIT_W-1:0] price_ext;
    logic [SLOTS-1:0]        sold_ext;

    assign price_ext = (SLOTS*CREDIT_W)'(price_table);
    assign sold_ext  = SLOTS'(sold_out);
    assign price     = price_ext[CREDIT_W*32'(sel_id) +: CREDIT_W];
    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));

`ifdef VEND_BONUS_DISCOUNT_EN
    assign charge = sale_q == SALE_W'(BONUS_N - 1) ? price - (price >> 2) : price;
`else
    assign charge = price;
`endif

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        id_d          = id_q;
        sale_d        = sale_q;
        err_funds_d   = 1'b0;
        err_empty_d   = 1'b0;
        dec_valid     = 1'b0;
        disp_valid    = 1'b0;
        chg_valid     = 1'b0;
        chg_coin      = change_coin(32'(credit_q));
        coin_ok       = (state_q == IDLE || state_q == CREDIT) && !coin_sum[CREDIT_W];
        coin_accept_d = coin_valid && coin_ok;
        coin_reject_d = coin_valid && !coin_ok;
        if (coin_accept_d) credit_d = coin_sum[CREDIT_W-1:0];
        case (state_q)
            IDLE: state_d = coin_accept_d ? CREDIT : IDLE;
            CREDIT: begin
                if (cancel) begin
                    state_d = CHANGE;
                end else if (sel_valid) begin
                    if (!SLOT_VALID[sel_id] || sold_ext[sel_id]) begin
                        err_empty_d = 1'b1;
                    end else if (credit_q < charge) begin
                        err_funds_d = 1'b1;
                    end else begin
                        id_d     = sel_id;
                        credit_d = credit_d - charge;
                        state_d  = VEND;
                    end
                end
            end
            VEND: begin
                disp_valid = 1'b1;
                if (disp_ready) begin
                    dec_valid = 1'b1;
                    sale_d    = sale_q == SALE_W'(BONUS_N - 1) ? '0 : sale_q + SALE_W'(1);
                    state_d   = credit_q != '0 ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit_q < CREDIT_W'(MIN_COIN)) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    chg_valid = 1'b1;
                    if (chg_ready) credit_d = credit_q - CREDIT_W'(coin_value(chg_coin));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            id_q          <= '0;
            sale_q        <= '0;
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            err_funds_q   <= 1'b0;
            err_empty_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            id_q          <= id_d;
            sale_q        <= sale_d;
            coin_accept_q <= coin_accept_d;
            coin_reject_q <= coin_reject_d;
            err_funds_q   <= err_funds_d;
            err_empty_q   <= err_empty_d;
        end
    end

    vend_stock_bank #(
        .NUM_PRODUCTS(NUM_PRODUCTS),
        .STOCK_W     (STOCK_W),
        .INIT_STOCK  (INIT_STOCK),
        .LOW_THRESH  (LOW_THRESH),
        .ID_W        (ID_W)
    ) u_stock (
        .clk          (clk),
        .reset_n      (reset_n),
        .restock_valid(restock_valid),
        .restock_id   (restock_id),
        .restock_qty  (restock_qty),
        .dec_valid    (dec_valid),
        .dec_id       (id_q),
        .rd_id        (sel_id),
        .rd_stock     (stock_out),
        .low_stock    (low_stock),
        .sold_out     (sold_out)
    );

    assign coin_accept = coin_accept_q;
    assign coin_reject = coin_reject_q;
    assign err_funds   = err_funds_q;
    assign err_empty   = err_empty_q;
    assign disp_id     = id_q;
    assign credit      = credit_q;
    assign state       = state_q;

endmodule
